block_assembler: RTL and testbench

BLOCK_ASSEMBLER -- requirements
Module: block_assembler

---
 rtl/block_assembler.sv | 103 ++++++++++
 tb/tb_block_assembler.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/block_assembler.sv
// -----------------------------------------------------------------------------
// block_assembler
//   Collects a raster stream of N-bit samples into 8x8 blocks using two
//   ping-pong banks. One bank can fill while the other is presented
//   downstream, so a 2-D DCT can consume whole blocks without stalling the
//   producer.
//
// Parameters
//   N          sample width in bits
//   TRANSPOSE  0 = k-th sample lands at row k/8, col k%8
//              1 = k-th sample lands at row k%8, col k/8
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_data carries a sample
//   in_data    one N-bit sample
//   in_ready   the write bank is EMPTY and can take a sample
//   out_valid  data_out holds a complete block
//   out_ready  downstream consumes the block this cycle
//   data_out   packed block, row r / col c at [(r*8+c)*N +: N]
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready and out_valid depend only on registered state, never on
// in_valid or out_ready, and data_out is held stable while out_valid = 1.
// -----------------------------------------------------------------------------
module block_assembler #(
  parameter int N         = 16,
  parameter int TRANSPOSE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N-1:0]    in_data,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [64*N-1:0] data_out
);

  // Storage and control state
  logic [64*N-1:0] bank_q [2];
  logic [1:0]      full_q,    full_d;     // 1 = FULL, 0 = EMPTY, per bank
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [5:0]      cnt_q,     cnt_d;

  logic            accept;
  logic            rd_done;
  logic [5:0]      wr_idx;

  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign data_out  = bank_q[rd_bank_q];

  assign accept  = in_valid & in_ready;
  assign rd_done = out_valid & out_ready;

  // Linear position r*8+c. Column-major fill swaps the row and column
  // fields of the counter, i.e. position = (k%8)*8 + k/8.
  assign wr_idx = (TRANSPOSE != 0) ? {cnt_q[2:0], cnt_q[5:3]} : cnt_q;

  // A completing write and a read release can never target the same bank:
  // accept needs the write bank EMPTY, release needs the read bank FULL.
  // Both flag updates therefore apply independently in one edge.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    cnt_d     = cnt_q;
    if (accept) begin
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'd63) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (rd_done) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0] <= '0;
      bank_q[1] <= '0;
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      cnt_q     <= 6'd0;
    end else begin
      if (accept) begin
        bank_q[wr_bank_q][int'(wr_idx)*N +: N] <= in_data;
      end
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_block_assembler.sv
// -----------------------------------------------------------------------------
// tb_block_assembler
//   Drives a row-major and a column-major instance from the same stream.
//   The reference model is simply the queue of accepted-but-unread samples:
//   the block on display is its first 64 entries, placed by the r/c rules,
//   in_ready is expected while fewer than 128 samples are held and out_valid
//   while at least 64 are held.
// -----------------------------------------------------------------------------
module tb_block_assembler;

  localparam int N  = 16;
  localparam int W  = 64 * N;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic [N-1:0]  in_data  = '0;
  logic          out_ready = 1'b0;

  logic          in_ready_rm, out_valid_rm;
  logic          in_ready_tr, out_valid_tr;
  logic [W-1:0]  data_out_rm, data_out_tr;

  block_assembler #(.N(N), .TRANSPOSE(0)) u_dut_rm (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_rm),
    .out_valid (out_valid_rm),
    .out_ready (out_ready),
    .data_out  (data_out_rm)
  );

  block_assembler #(.N(N), .TRANSPOSE(1)) u_dut_tr (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_tr),
    .out_valid (out_valid_tr),
    .out_ready (out_ready),
    .data_out  (data_out_tr)
  );

  // Scoreboard state
  logic [N-1:0] exp_q[$];
  int n_tests   = 0;
  int n_fail    = 0;
  int stall_cnt = 0;   // cycles offering a sample while DUT in_ready = 0
  int pulse_cnt = 0;   // DUT read handshakes observed
  int model_rel = 0;   // read handshakes predicted by the model

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Compare a packed block in 64-bit chunks to keep report lines short.
  task automatic check_block(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    for (int i = 0; i < W / 64; i++) begin
      check(tag, got[i*64 +: 64], exp[i*64 +: 64]);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e_rm, e_tr;
    int held;
    held = exp_q.size();
    check("in_ready_rm",  in_ready_rm,  held < 128);
    check("in_ready_tr",  in_ready_tr,  held < 128);
    check("out_valid_rm", out_valid_rm, held >= 64);
    check("out_valid_tr", out_valid_tr, held >= 64);
    if (held >= 64) begin
      e_rm = '0;
      e_tr = '0;
      for (int k = 0; k < 64; k++) begin
        e_rm[k*N +: N]                   = exp_q[k];
        e_tr[((k % 8) * 8 + k / 8)*N +: N] = exp_q[k];
      end
      check_block("data_rm", data_out_rm, e_rm);
      check_block("data_tr", data_out_tr, e_tr);
    end
  endtask

  // One clock cycle. Entered 1 time unit after a rising edge.
  task automatic step(input logic v, input logic [N-1:0] d, input logic ordy);
    logic acc, rel;
    check_outputs();
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    acc = v && (exp_q.size() < 128);
    rel = ordy && (exp_q.size() >= 64);
    if (v && !in_ready_rm) stall_cnt++;
    if (out_valid_rm && ordy) pulse_cnt++;
    @(posedge clk);
    #1;
    if (rel) begin
      for (int i = 0; i < 64; i++) void'(exp_q.pop_front());
      model_rel++;
    end
    if (acc) exp_q.push_back(d);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready_rm",  in_ready_rm,  1'b1);
    check("rst_in_ready_tr",  in_ready_tr,  1'b1);
    check("rst_out_valid_rm", out_valid_rm, 1'b0);
    check("rst_out_valid_tr", out_valid_tr, 1'b0);
    check_block("rst_data_rm", data_out_rm, '0);
    check_block("rst_data_tr", data_out_tr, '0);
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;

    // Reset state
    do_reset();

    // One block 0..63 with no reader: out_valid right after sample 63
    for (int i = 0; i < 64; i++) step(1'b1, N'(i), 1'b0);
    check("blk0_out_valid", out_valid_rm, 1'b1);
    // Second block 64..127 and sample 128 held off while both banks are full
    for (int i = 64; i < 128; i++) step(1'b1, N'(i), 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, N'(128), 1'b0);
    check("both_full_in_ready", in_ready_rm, 1'b0);
    // Release one block for a single cycle, then observe block 64..127
    step(1'b1, N'(128), 1'b1);
    step(1'b0, N'(0), 1'b0);
    check("after_release_in_ready", in_ready_rm, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, N'(0), 1'b0);

    // Sustained throughput: 4 blocks, continuous valid and ready
    do_reset();
    stall_cnt = 0;
    pulse_cnt = 0;
    for (int i = 0; i < 256; i++) step(1'b1, N'($urandom), 1'b1);
    step(1'b0, N'(0), 1'b1);
    step(1'b0, N'(0), 1'b1);
    check("stream_stalls", stall_cnt, 0);
    check("stream_blocks", pulse_cnt, 4);

    // Reset in the middle of a block, then a clean block
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, N'(1000 + i), 1'b0);
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b1, N'(2000 + i), 1'b0);
    check("post_rst_out_valid", out_valid_rm, 1'b1);
    step(1'b0, N'(0), 1'b1);

    // Random valid/ready traffic
    do_reset();
    pulse_cnt = 0;
    model_rel = 0;
    cyc = 0;
    while (pulse_cnt < 300 && cyc < 70000) begin
      step(1'($urandom_range(0, 1)), N'($urandom), 1'($urandom_range(0, 1)));
      cyc++;
    end
    check("rand_blocks_done", pulse_cnt, 300);
    check("rand_blocks_model", pulse_cnt, model_rel);
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
